// File: rtl/pc_branch_ctrl_if.sv
// pc_branch_ctrl_if: the branch/stall inputs and the PC/issue outputs of
// pc_branch_ctrl, bundled into one interface.
// The optional taken_count signal exists only when PC_BRANCH_COUNT_EN is
// defined.
interface pc_branch_ctrl_if;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;

  logic [PC_W-1:0]  entrada_mux;
  logic             branch;
  logic             zero;
  logic             stall;
  logic [PC_W-1:0]  estado_pc;
  logic             instr_valid;
  logic             flush;
`ifdef PC_BRANCH_COUNT_EN
  logic [CNT_W-1:0] taken_count;
`endif

  // Pipeline side: drives the branch/stall inputs and observes the PC outputs.
  modport master (
    output entrada_mux, branch, zero, stall,
`ifdef PC_BRANCH_COUNT_EN
    input  taken_count,
`endif
    input  estado_pc, instr_valid, flush
  );

  // Controller side.
  modport slave (
    input  entrada_mux, branch, zero, stall,
`ifdef PC_BRANCH_COUNT_EN
    output taken_count,
`endif
    output estado_pc, instr_valid, flush
  );
endinterface

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: keeps the word-indexed PC and handles branch redirects and
// hazard stalls using a RUN / FLUSH / STALL state machine.
//
// A taken branch is (branch & zero). It is ignored while in FLUSH, because
// that cycle's instruction is on the wrong path. A taken branch wins over
// stall.
//
// Define PC_BRANCH_COUNT_EN to add taken_count, a 16-bit saturating count
// of accepted redirects.
module pc_branch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clock,
  input  logic           reset,
  pc_branch_ctrl_if.slave bus
);
  localparam int unsigned PC_W  = 32;
`ifdef PC_BRANCH_COUNT_EN
  localparam int unsigned CNT_W = 16;
`endif

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              iv_q, iv_d;
  logic              fl_q, fl_d;
  logic              taken_c;

  // A branch counts only outside FLUSH; the FLUSH-cycle instruction is squashed.
  assign taken_c = bus.branch & bus.zero & (state_q != ST_FLUSH);

  // Next-state logic: redirect, hold, or step the PC forward.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iv_d    = 1'b0;
    fl_d    = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (taken_c) begin
          pc_d    = bus.entrada_mux;
          iv_d    = 1'b1;
          fl_d    = 1'b1;
          state_d = ST_FLUSH;
        end else if (bus.stall) begin
          state_d = ST_STALL;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          iv_d    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (bus.stall) begin
          state_d = ST_STALL;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          iv_d    = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      iv_q    <= 1'b0;
      fl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iv_q    <= iv_d;
      fl_q    <= fl_d;
    end
  end

  assign bus.estado_pc   = pc_q;
  assign bus.instr_valid = iv_q;
  assign bus.flush       = fl_q;

`ifdef PC_BRANCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count accepted redirects, holding at all-ones once the count is full.
  always_comb begin
    cnt_d = cnt_q;
    if (taken_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Redirect counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.taken_count = cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb_pc_branch_ctrl: scoreboard bench for two pc_branch_ctrl instances.
// dut0 uses RESET_PC = 0. dut1 uses RESET_PC = FFFF_FFFF, so every reset
// exercises the PC wrap-around.
// Both instances receive the same branch/zero/stall/reset stimulus, each
// with its own target.
// Expected values come from a cycle-level model of the PC rules.
module tb_pc_branch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pc_branch_ctrl_if bus0();
  pc_branch_ctrl_if bus1();

  pc_branch_ctrl #(.RESET_PC(32'h0000_0000)) dut0 (.clock(clk), .reset(rst), .bus(bus0.slave));
  pc_branch_ctrl #(.RESET_PC(32'hFFFF_FFFF)) dut1 (.clock(clk), .reset(rst), .bus(bus1.slave));

  typedef struct packed {
    logic [31:0] pc;
    logic        iv;
    logic        fl;
    logic [15:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int vectors     = 0;
  int miscompares = 0;

  // Model state: current PC, whether the last edge produced a redirect, and the redirect count.
  logic [31:0] m_pc  [2];
  logic        m_red [2];
  logic [15:0] m_cnt [2];
  logic [31:0] m_rst_pc [2];

  // Advance the model by one clock edge for instance i and return the expected outputs.
  function automatic exp_t model(input int i, input logic rs, input logic br,
                                 input logic z, input logic st, input logic [31:0] tgt);
    exp_t e;
    if (rs) begin
      m_pc[i]  = m_rst_pc[i];
      m_red[i] = 1'b0;
      m_cnt[i] = 16'd0;
      e.iv = 1'b0;
    end else if (br && z && !m_red[i]) begin
      m_pc[i]  = tgt;
      m_red[i] = 1'b1;
      if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
      e.iv = 1'b1;
    end else if (st) begin
      m_red[i] = 1'b0;
      e.iv = 1'b0;
    end else begin
      m_pc[i]  = m_pc[i] + 32'd1;
      m_red[i] = 1'b0;
      e.iv = 1'b1;
    end
    e.pc  = m_pc[i];
    e.fl  = m_red[i];
    e.cnt = m_cnt[i];
    return e;
  endfunction

  // Drive one cycle of stimulus and push the expected response for each instance.
  task automatic apply(input logic rs, input logic br, input logic z, input logic st,
                       input logic [31:0] t0, input logic [31:0] t1);
    @(negedge clk);
    rst = rs;
    bus0.branch = br; bus0.zero = z; bus0.stall = st; bus0.entrada_mux = t0;
    bus1.branch = br; bus1.zero = z; bus1.stall = st; bus1.entrada_mux = t1;
    q0.push_back(model(0, rs, br, z, st, t0));
    q1.push_back(model(1, rs, br, z, st, t1));
  endtask

  // Compare one DUT output against its expected value.
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endfunction

  // Monitor: after each active edge, pop the expected outputs and compare them with the DUT.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("dut0.estado_pc", bus0.estado_pc, e.pc);
      check("dut0.instr_valid", 32'(bus0.instr_valid), 32'(e.iv));
      check("dut0.flush", 32'(bus0.flush), 32'(e.fl));
`ifdef PC_BRANCH_COUNT_EN
      check("dut0.taken_count", 32'(bus0.taken_count), 32'(e.cnt));
`endif
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("dut1.estado_pc", bus1.estado_pc, e.pc);
      check("dut1.instr_valid", 32'(bus1.instr_valid), 32'(e.iv));
      check("dut1.flush", 32'(bus1.flush), 32'(e.fl));
`ifdef PC_BRANCH_COUNT_EN
      check("dut1.taken_count", 32'(bus1.taken_count), 32'(e.cnt));
`endif
    end
  end

  // Timeout: stop with a FAIL line if the run overruns its time limit.
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic rs, br, z, st;
    logic [31:0] t0, t1;
    m_rst_pc[0] = 32'h0000_0000;
    m_rst_pc[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 32'h0; m_red[i] = 1'b0; m_cnt[i] = 16'h0;
    end
    bus0.branch = 1'b0; bus0.zero = 1'b0; bus0.stall = 1'b0; bus0.entrada_mux = 32'h0;
    bus1.branch = 1'b0; bus1.zero = 1'b0; bus1.stall = 1'b0; bus1.entrada_mux = 32'h0;

    // Reset, then free-run: PC counts 0,1,2,3... and dut1 wraps from FFFF_FFFF to 0.
    apply(1, 0, 0, 0, 32'd0, 32'd0);
    apply(1, 0, 0, 0, 32'd0, 32'd0);
    for (int k = 0; k < 5; k++) apply(0, 0, 0, 0, 32'd0, 32'd0);
    // Taken branch at PC 5 goes to 20; a taken branch in the flush cycle is ignored (PC 21).
    apply(0, 1, 1, 0, 32'd20, 32'd100);
    apply(0, 1, 1, 0, 32'd40, 32'd200);
    // Not-taken branch, two stall cycles, then release.
    apply(0, 1, 0, 0, 32'd50, 32'd50);
    apply(0, 0, 0, 1, 32'd0, 32'd0);
    apply(0, 0, 0, 1, 32'd0, 32'd0);
    apply(0, 0, 0, 0, 32'd0, 32'd0);
    // From STALL, a taken branch beats stall; a stall during FLUSH goes to STALL.
    apply(0, 0, 0, 1, 32'd0, 32'd0);
    apply(0, 1, 1, 1, 32'd3, 32'd7);
    apply(0, 1, 1, 1, 32'd9, 32'd9);
    apply(0, 0, 0, 0, 32'd0, 32'd0);
    // Redirect to the current PC, then reset asserted during FLUSH.
    apply(0, 1, 1, 0, m_pc[0], m_pc[1]);
    apply(0, 1, 1, 0, 32'd11, 32'd11);
    apply(0, 1, 1, 0, 32'd30, 32'd31);
    apply(1, 1, 1, 0, 32'd60, 32'd60);
    apply(0, 1, 1, 0, 32'd70, 32'd71);
    // Three taken branches, each followed by two idle cycles.
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 1, 0, 32'(100 + 10 * k), 32'(200 + 10 * k));
      apply(0, 0, 0, 0, 32'd0, 32'd0);
      apply(0, 0, 0, 0, 32'd0, 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      rs = ($urandom_range(63) == 0);
      br = 1'($urandom_range(1));
      z  = ($urandom_range(3) != 0);
      st = ($urandom_range(3) == 0);
      t0 = ($urandom_range(7) == 0) ? m_pc[0] : 32'($urandom);
      t1 = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      apply(rs, br, z, st, t0, t1);
    end

    apply(0, 0, 0, 0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
